// File: rtl/enc_pkg.sv
// Shared definitions for the encoder pipeline sequencer and its datapath.
package enc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACT    = 3'd3,
        ST_LAMBDA = 3'd4,
        ST_FINISH = 3'd5,
        ST_ERR    = 3'd6
    } enc_state_t;

    // act_sel encoding seen by the activation unit
    localparam logic ACT_SOFTPLUS = 1'b0;
    localparam logic ACT_SIGMOID  = 1'b1;

    // Default pipeline shape and phase lengths (cycles)
    localparam int ENC_N_STAGE      = 4;
    localparam int ENC_CNT_W        = 7;
    localparam int ENC_ACT_CC       = 3;
    localparam int ENC_LAMBDA_CC    = 8;
    localparam int ENC_LAMBDA_AFTER = 1;
    localparam int ENC_TIMEOUT_CC   = 64;

endpackage

// File: rtl/enc_phase_timer.sv
// Loadable down-counter with terminal-count flag. One instance is shared by
// the WAIT (watchdog), ACT and LAMBDA phases; the FSM loads length-1 on phase
// entry and leaves the phase in the cycle where tc is high.
module enc_phase_timer
    import enc_pkg::*;
#(
    parameter int CNT_W = ENC_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;

    // Count down to zero and stop there; load and clear take priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/enc_sequencer.sv
// Handshake sequencer for the four-layer encoder: start pulse per layer,
// wait for done (with watchdog), activation window, optional lambda window.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | after reset, waiting for run
//   START     | one-cycle stage_start[idx] pulse
//   WAIT      | waiting for stage_done[idx]; watchdog running
//   ACT       | activation window (sigmoid on the last layer)
//   LAMBDA    | reparameterisation window after layer LAMBDA_AFTER
//   FINISH    | inference complete, done_flag held until next run
//   ERR       | watchdog fired, err_timeout held until next run
module enc_sequencer
    import enc_pkg::*;
#(
    parameter int N_STAGE      = ENC_N_STAGE,
    parameter int CNT_W        = ENC_CNT_W,
    parameter int ACT_CC       = ENC_ACT_CC,
    parameter int LAMBDA_CC    = ENC_LAMBDA_CC,
    parameter int LAMBDA_AFTER = ENC_LAMBDA_AFTER,
    parameter int TIMEOUT_CC   = ENC_TIMEOUT_CC
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic [N_STAGE-1:0] stage_done,
    output logic [N_STAGE-1:0] stage_start,
    output logic               act_en,
    output logic               act_sel,
    output logic               lambda_en,
    output logic               busy,
    output logic               done_flag,
    output logic               err_timeout,
    output logic [2:0]         debug_state,
    output logic [CNT_W-1:0]   debug_cc
);

    localparam int IDX_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_STAGE - 1);
    localparam logic [IDX_W-1:0] LAMBDA_IDX = IDX_W'(LAMBDA_AFTER);
    localparam logic [CNT_W-1:0] WAIT_LD    = CNT_W'(TIMEOUT_CC - 1);
    localparam logic [CNT_W-1:0] ACT_LD     = CNT_W'(ACT_CC - 1);
    localparam logic [CNT_W-1:0] LAMBDA_LD  = CNT_W'(LAMBDA_CC - 1);

    enc_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cc_q, cc_d;

    logic             tmr_clr, tmr_load, tmr_tc;
    logic [CNT_W-1:0] tmr_val;

    logic [N_STAGE-1:0] start_d;
    logic               act_en_d, act_sel_d, lambda_en_d;
    logic               busy_d, done_d, err_d;

    enc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // State, stage index and phase counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cc_q    <= cc_d;
        end
    end

    // Next state, timer control and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cc_d        = cc_q;
        tmr_clr     = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        start_d     = '0;
        act_en_d    = 1'b0;
        act_sel_d   = ACT_SOFTPLUS;
        lambda_en_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE, ST_FINISH, ST_ERR: begin
                if (run) begin
                    state_d = ST_START;
                    idx_d   = '0;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done is checked first so it wins over a coincident timeout
                if (stage_done[idx_q]) begin
                    state_d = ST_ACT;
                end else if (tmr_tc) begin
                    state_d = ST_ERR;
                end
            end
            ST_ACT: begin
                if (tmr_tc) begin
                    if (idx_q == LAMBDA_IDX) begin
                        state_d = ST_LAMBDA;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_START;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_LAMBDA: begin
                if (tmr_tc) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_START;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        // Phase counter restarts on every state change and saturates.
        if (state_d != state_q) begin
            cc_d = '0;
        end else if (state_q == ST_WAIT || state_q == ST_ACT || state_q == ST_LAMBDA) begin
            cc_d = (cc_q == '1) ? cc_q : cc_q + CNT_W'(1);
        end

        if (state_d != state_q) begin
            case (state_d)
                ST_WAIT: begin
                    tmr_load = 1'b1;
                    tmr_val  = WAIT_LD;
                end
                ST_ACT: begin
                    tmr_load = 1'b1;
                    tmr_val  = ACT_LD;
                end
                ST_LAMBDA: begin
                    tmr_load = 1'b1;
                    tmr_val  = LAMBDA_LD;
                end
                ST_IDLE, ST_FINISH, ST_ERR: begin
                    tmr_clr = 1'b1;
                end
                default: begin
                    tmr_load = 1'b0;
                end
            endcase
        end

        if (state_d == ST_START) begin
            start_d[idx_d] = 1'b1;
        end
        act_en_d    = (state_d == ST_ACT);
        act_sel_d   = (state_d == ST_ACT && idx_d == LAST_IDX) ? ACT_SIGMOID : ACT_SOFTPLUS;
        lambda_en_d = (state_d == ST_LAMBDA);
        busy_d      = (state_d == ST_START) || (state_d == ST_WAIT) ||
                      (state_d == ST_ACT)   || (state_d == ST_LAMBDA);
        done_d      = (state_d == ST_FINISH);
        err_d       = (state_d == ST_ERR);
    end

    // Output registers, loaded from the next-state decode so they line up with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_start <= '0;
            act_en      <= 1'b0;
            act_sel     <= ACT_SOFTPLUS;
            lambda_en   <= 1'b0;
            busy        <= 1'b0;
            done_flag   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            stage_start <= start_d;
            act_en      <= act_en_d;
            act_sel     <= act_sel_d;
            lambda_en   <= lambda_en_d;
            busy        <= busy_d;
            done_flag   <= done_d;
            err_timeout <= err_d;
        end
    end

    assign debug_state = state_q;
    assign debug_cc    = cc_q;

endmodule

// File: tb/tb_enc_sequencer.sv
// Bench for enc_sequencer: each scenario is turned into a per-cycle table of
// expected outputs from the layer latencies, then the DUT is stepped through it.
module tb_enc_sequencer;
    import enc_pkg::*;

    localparam int NS        = 4;
    localparam int ACT_N     = 3;
    localparam int LAM_N     = 8;
    localparam int LAM_AFTER = 1;
    localparam int TMO       = 64;
    localparam int MAXC      = 512;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] stage_done = '0;
    logic [3:0] stage_start;
    logic       act_en, act_sel, lambda_en, busy, done_flag, err_timeout;
    logic [2:0] debug_state;
    logic [6:0] debug_cc;
    logic [9:0] outv;

    always #5 clk = ~clk;

    enc_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .act_en      (act_en),
        .act_sel     (act_sel),
        .lambda_en   (lambda_en),
        .busy        (busy),
        .done_flag   (done_flag),
        .err_timeout (err_timeout),
        .debug_state (debug_state),
        .debug_cc    (debug_cc)
    );

    // bit 9:6 stage_start, 5 act_en, 4 act_sel, 3 lambda_en, 2 busy, 1 done_flag, 0 err_timeout
    assign outv = {stage_start, act_en, act_sel, lambda_en, busy, done_flag, err_timeout};

    int errors = 0;
    int checks = 0;

    logic [9:0] exp_v  [MAXC];
    logic       run_v  [MAXC];
    logic [3:0] done_v [MAXC];

    int lat  [NS];
    int hold [NS];
    bit spur_en;
    int xruns;
    int nc;
    int rst_at = 0;
    int obs_start [NS];
    int obs_fin;
    int obs_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add_spur(input int i, input int lo, input int hi);
        int c;
        int j;
        c = lo + int'($urandom_range(hi - lo));
        j = (i + 1 + int'($urandom_range(2))) % NS;
        done_v[c][j] = 1'b1;
    endtask

    // Expected waveform from the schedule: start, wait lat, ACT window,
    // lambda window after LAM_AFTER, then FINISH; a missing done means ERR.
    task automatic build_scn();
        int  s, t, nx, fin;
        bit  is_err;
        for (int c = 0; c < MAXC; c++) begin
            exp_v[c]  = '0;
            run_v[c]  = 1'b0;
            done_v[c] = '0;
        end
        run_v[0] = 1'b1;
        s = 1;
        fin = 0;
        is_err = 1'b0;
        for (int i = 0; i < NS; i++) begin
            exp_v[s][6+i] = 1'b1;
            if (lat[i] == 0 || lat[i] > TMO) begin
                if (lat[i] > 0) begin
                    for (int h = 0; h < hold[i]; h++) done_v[s+lat[i]+h][i] = 1'b1;
                end
                if (spur_en) add_spur(i, s + 1, s + TMO);
                fin = s + TMO + 1;
                is_err = 1'b1;
                break;
            end
            t = s + lat[i];
            for (int h = 0; h < hold[i]; h++) done_v[t+h][i] = 1'b1;
            if (spur_en && lat[i] >= 2) add_spur(i, s + 1, t - 1);
            for (int c = t + 1; c <= t + ACT_N; c++) begin
                exp_v[c][5] = 1'b1;
                exp_v[c][4] = (i == NS - 1);
            end
            nx = t + ACT_N + 1;
            if (i == LAM_AFTER) begin
                for (int c = nx; c < nx + LAM_N; c++) exp_v[c][3] = 1'b1;
                nx = nx + LAM_N;
            end
            if (i == NS - 1) fin = nx;
            else s = nx;
        end
        for (int c = 1; c < fin; c++) exp_v[c][2] = 1'b1;
        nc = fin + 8;
        for (int c = fin; c < nc; c++) begin
            if (is_err) exp_v[c][0] = 1'b1;
            else exp_v[c][1] = 1'b1;
        end
        for (int k = 0; k < xruns; k++) run_v[1 + int'($urandom_range(fin - 2))] = 1'b1;
    endtask

    task automatic exec_scn(input string name);
        for (int i = 0; i < NS; i++) obs_start[i] = -1;
        obs_fin = -1;
        obs_err = -1;
        for (int c = 0; c < nc; c++) begin
            run = run_v[c];
            stage_done = done_v[c];
            if (rst_at > 0 && c == rst_at) begin
                reset_n = 1'b0;
                #1;
                check_val($sformatf("%s_rst_async", name), 32'({outv, debug_cc}), 32'(0));
            end
            if (rst_at > 0 && c == rst_at + 2) reset_n = 1'b1;
            @(negedge clk);
            if (c > 0) begin
                check_val($sformatf("%s_c%0d", name, c), 32'(outv), 32'(exp_v[c]));
                for (int i = 0; i < NS; i++)
                    if (obs_start[i] < 0 && stage_start[i]) obs_start[i] = c;
                if (obs_fin < 0 && done_flag) obs_fin = c;
                if (obs_err < 0 && err_timeout) obs_err = c;
            end
            @(posedge clk);
            #1;
        end
        run = 1'b0;
        stage_done = '0;
        rst_at = 0;
    endtask

    task automatic set_nominal();
        for (int i = 0; i < NS; i++) begin
            lat[i]  = 5;
            hold[i] = 1;
        end
        spur_en = 1'b0;
        xruns   = 0;
    endtask

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_outputs", 32'(outv), 32'(0));
        check_val("rst_cc", 32'(debug_cc), 32'(0));
        check_val("rst_state", 32'(debug_state), 32'(ST_IDLE));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // nominal schedule
        set_nominal();
        build_scn();
        exec_scn("nominal");
        check_val("nom_start0", 32'(obs_start[0]), 32'(1));
        check_val("nom_start1", 32'(obs_start[1]), 32'(10));
        check_val("nom_start2", 32'(obs_start[2]), 32'(27));
        check_val("nom_start3", 32'(obs_start[3]), 32'(36));
        check_val("nom_finish", 32'(obs_fin), 32'(45));

        // stage 2 never answers
        set_nominal();
        lat[2] = 0;
        build_scn();
        exec_scn("timeout");
        check_val("tmo_err_cycle", 32'(obs_err), 32'(27 + TMO + 1));

        // a new run clears err_timeout
        set_nominal();
        build_scn();
        exec_scn("after_err");
        check_val("after_err_finish", 32'(obs_fin), 32'(45));

        // done lands on the last watchdog cycle
        set_nominal();
        lat[0] = TMO;
        build_scn();
        exec_scn("coincident");
        check_val("coin_start1", 32'(obs_start[1]), 32'(1 + TMO + ACT_N + 1));
        check_val("coin_no_err", 32'(obs_err), 32'(-1));

        // spurious done[3] while waiting on stage 0
        set_nominal();
        build_scn();
        done_v[3][3] = 1'b1;
        exec_scn("spurious");
        check_val("spur_start1", 32'(obs_start[1]), 32'(10));

        // run pulsed during stage 1 ACT window
        set_nominal();
        build_scn();
        run_v[17] = 1'b1;
        exec_scn("run_busy");
        check_val("rb_start2", 32'(obs_start[2]), 32'(27));

        // reset in the 4th lambda cycle
        set_nominal();
        build_scn();
        rst_at = 22;
        for (int c = 22; c < MAXC; c++) begin
            exp_v[c] = '0;
            run_v[c] = 1'b0;
        end
        nc = 30;
        exec_scn("rst_lambda");
        set_nominal();
        build_scn();
        exec_scn("after_rst");
        check_val("after_rst_start0", 32'(obs_start[0]), 32'(1));

        // randomized latencies, holds, spurious dones and ignored runs
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NS; i++) begin
                r = int'($urandom_range(99));
                if (r < 4) lat[i] = 0;
                else if (r < 10) lat[i] = TMO - 1 + int'($urandom_range(1));
                else if (r < 13) lat[i] = TMO + 1 + int'($urandom_range(3));
                else lat[i] = 1 + int'($urandom_range(12));
                hold[i] = 1 + int'($urandom_range(2));
            end
            spur_en = ($urandom_range(1) == 1);
            xruns   = int'($urandom_range(2));
            build_scn();
            exec_scn($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enc_sequencer.md
# enc_sequencer

Handshake-driven sequencer for the four-layer encoder pipeline.
- Issues a one-cycle start pulse to each encoder layer in order and waits for that layer's done.
- Then runs the post-layer activation window (softplus or sigmoid) and, after the configured layer, the lambda (reparameterisation) window.
- Flags completion, or a watchdog timeout if a layer stalls.
- Replaces fixed cycle-count start scheduling, so layer latencies can change without retuning the controller.

## Interface
- N_STAGE, 4, number of encoder layers sequenced
- CNT_W, 7, width of the phase/watchdog counter
- ACT_CC, 3, activation window length in cycles (1..2^CNT_W-1)
- LAMBDA_CC, 8, lambda window length in cycles (1..2^CNT_W-1)
- LAMBDA_AFTER, 1, stage index followed by the lambda window
- TIMEOUT_CC, 64, maximum cycles waited for a stage done (1..2^CNT_W-1)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- run  input  1  start-of-inference request, sampled each cycle
- stage_done  input  N_STAGE  per-layer completion, level or pulse
- stage_start  output  N_STAGE  one-hot, one-cycle start pulse per layer
- act_en  output  1  activation unit enable
- act_sel  output  1  0 = softplus, 1 = sigmoid
- lambda_en  output  1  lambda/reparam unit enable
- busy  output  1  high from accepted run until FINISH or ERR
- done_flag  output  1  inference complete; held until next accepted run
- err_timeout  output  1  watchdog fired; held until next accepted run
- debug_state  output  3  current FSM state encoding
- debug_cc  output  CNT_W  current phase counter

## Operation
- States: IDLE, START, WAIT, ACT, LAMBDA, FINISH, ERR. A stage index idx (0..N_STAGE-1) and a counter cc are kept.
- IDLE, FINISH or ERR with run=1 -> START. On entry: idx=0, cc=0, done_flag=0, err_timeout=0, busy=1.
- run while busy=1 is ignored.
- START: stage_start[idx]=1 for exactly one cycle, then -> WAIT with cc=0.
- WAIT: cc increments each cycle.
  - stage_done[idx]=1 -> ACT, cc=0.
  - cc reaches TIMEOUT_CC-1 without done -> ERR.
  - If done and timeout coincide, done wins.
  - stage_done bits other than idx are ignored.
- ACT: act_en=1 for ACT_CC cycles. act_sel=1 when idx==N_STAGE-1, else 0. At the end of the window:
  - if idx==LAMBDA_AFTER -> LAMBDA;
  - else if idx==N_STAGE-1 -> FINISH;
  - else idx+1 -> START.
- LAMBDA: lambda_en=1 for LAMBDA_CC cycles, then idx+1 -> START. If LAMBDA_AFTER==N_STAGE-1, go to FINISH instead.
- FINISH: busy=0, done_flag=1.
- ERR: busy=0, err_timeout=1, all enables 0.
- Arithmetic: cc saturates at 2^CNT_W-1. The idx increment never wraps, because FINISH is taken at N_STAGE-1.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, idx=0, cc=0, stage_start=0, act_en=0, act_sel=0, lambda_en=0, busy=0, done_flag=0, err_timeout=0.
- reset_n low mid-operation returns to these values immediately, asynchronously. Release is synchronous to clk.
- Phase timings:
  - run sampled high at edge k -> busy and stage_start[0] high in cycle k+1.
  - stage_done[idx] sampled at edge t -> act_en high in cycles t+1 .. t+ACT_CC.
  - Next stage_start is in cycle t+ACT_CC+1, or t+ACT_CC+LAMBDA_CC+1 after the lambda window.
- Last ACT window ends at cycle e -> done_flag=1, busy=0 in cycle e+1.
- stage_start[idx] is issued in cycle s. If stage_done[idx] is still low by the TIMEOUT_CC-th WAIT cycle (cycle s+TIMEOUT_CC), then err_timeout=1 in cycle s+TIMEOUT_CC+1.
- act_en, lambda_en and stage_start are never high in the same cycle.

## Structure
- Shared package enc_pkg:
  - state enumeration (3-bit) and ACT_SOFTPLUS/ACT_SIGMOID constants;
  - default ACT_CC, LAMBDA_CC, TIMEOUT_CC values, also used by the datapath.
- One natural sub-module, enc_phase_timer. It is a loadable down-counter with a terminal-count output and a clear, shared by the WAIT, ACT and LAMBDA phases.
- The FSM and output registers stay in enc_sequencer.

## Test plan
- Nominal run: defaults, each stage_done returns 5 cycles after its start.
  - Expect stage_start pulses at cycles 1, 10, 27, 36.
  - Expect act_sel=1 only during the last ACT window.
  - Expect lambda_en high for 8 cycles after stage 1.
  - Expect done_flag=1 and busy=0 at cycle 45.
- Timeout: stage 2 done never arrives. Expect err_timeout=1 exactly TIMEOUT_CC+1=65 cycles after stage_start[2], busy=0, all enables 0; a new run clears err_timeout.
- Coincident done and timeout: stage_done[0] is asserted on the same edge that cc reaches TIMEOUT_CC-1. Expect ACT, not ERR.
- Spurious done: stage_done[3] is pulsed while waiting on stage 0. Expect no state change; the stage 0 flow is unaffected.
- run while busy: pulse run during the stage 1 ACT window. Expect no restart; stage_start[2] timing is unchanged.
- Reset mid-LAMBDA: drive reset_n low in the 4th lambda cycle. Expect all outputs at their reset values in the same cycle; after release, a run restarts from stage 0.
